// File: rtl/op_display_pkg.sv
// Purpose: shared opcode enum and instruction classifier for the opcode display path.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package op_display_pkg;

  // 4-bit display opcode; the 7-segment decoder uses the same encoding.
  typedef enum logic [3:0] {
    OP_MOV   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_ORR   = 4'd4,
    OP_CMP   = 4'd5,
    OP_MVN   = 4'd6,
    OP_LDR   = 4'd7,
    OP_STR   = 4'd8,
    OP_B     = 4'd9,
    OP_BX    = 4'd10,
    OP_UNDEF = 4'd15
  } op_code_t;

  // Rule order matters: BX is a data-processing-class encoding and must be
  // caught before the generic 27:26 == 00 decode.
  function automatic op_code_t classify_instr(input logic [31:0] instr);
    op_code_t code;
    code = OP_UNDEF;
    if (instr[27:4] == 24'h12FFF1) begin
      code = OP_BX;
    end else if (instr[27:25] == 3'b101) begin
      code = OP_B;
    end else if (instr[27:26] == 2'b01) begin
      code = instr[20] ? OP_LDR : OP_STR;
    end else if (instr[27:26] == 2'b00) begin
      case (instr[24:21])
        4'b1101: code = OP_MOV;
        4'b0100: code = OP_ADD;
        4'b0010: code = OP_SUB;
        4'b0000: code = OP_AND;
        4'b1100: code = OP_ORR;
        4'b1010: code = OP_CMP;
        4'b1111: code = OP_MVN;
        default: code = OP_UNDEF;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/op_display_queue_fifo.sv
// Purpose: DEPTH x 4-bit synchronous FIFO of display opcodes (op_fifo).
// Latency: a pushed entry is visible on head_dat the cycle after the push edge.
// Backpressure: push ignored while full (no push-through), pop ignored while empty.
//
// Ports: clk/rst_n; push + push_dat write; pop advances the head;
//        head_dat is the oldest entry; full/empty/count from the count register.
module op_fifo
  import op_display_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  op_code_t      push_dat,
  input  logic          pop,
  output op_code_t      head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  op_code_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // full/empty come only from the count register so the ready path never
  // depends on the incoming valid.
  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/op_display_queue.sv
// Purpose: classify retired instructions into display opcodes, queue them, show each for a minimum dwell.
// Latency: with an empty queue and dwell expired, a word accepted at edge N is on op after edge N+1.
// Backpressure: instr_ready = !full (from the count register only); freeze pauses display, not pushes.
//
// Ports: clk, rst_n (async, active-low); instr/instr_valid/instr_ready push handshake;
//        freeze holds op and pauses the dwell counter; op is the registered display code;
//        pending is the number of queued codes not yet displayed.
module op_display_queue
  import op_display_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic                         freeze,
  output logic [3:0]                   op,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int CW     = $clog2(DEPTH + 1);
  localparam int CNT_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  op_code_t          push_code;
  op_code_t          head_code;
  op_code_t          op_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              dwell_done;

  // Only the 4-bit code is stored; classification happens on the way in.
  assign push_code   = classify_instr(instr);
  assign instr_ready = !fifo_full;
  assign push        = instr_valid && !fifo_full;
  assign pop         = !fifo_empty && dwell_done && !freeze;
  assign op          = op_q;
  assign pending     = fifo_count;

  op_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_code),
    .pop      (pop),
    .head_dat (head_code),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // dwell_done resets to 1 so the first code after reset is shown at once.
  // The done flag rises one edge after the counter reaches DWELL_LAST, which
  // together with the load edge gives a hold of DWELL_CYCLES+1 edges; with
  // DWELL_CYCLES == 1 that is one load cycle plus one counting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_UNDEF;
      dwell_cnt  <= '0;
      dwell_done <= 1'b1;
    end else if (pop) begin
      op_q       <= head_code;
      dwell_cnt  <= '0;
      dwell_done <= 1'b0;
    end else if (!dwell_done && !freeze) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_done <= 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_op_display_queue.sv
module tb_op_display_queue;

  localparam int DEPTH = 4;
  localparam int DWELL = 5;
  localparam int PW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (DWELL=5)
  logic          rst_n, vld, frz, rdy;
  logic [31:0]   ins;
  logic [3:0]    op;
  logic [PW-1:0] pend;

  // classification instance (DWELL=1)
  logic          f_rst_n, f_vld, f_rdy;
  logic [31:0]   f_ins;
  logic [3:0]    f_op;
  logic [PW-1:0] f_pend;

  op_display_queue #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .instr(ins), .instr_valid(vld), .instr_ready(rdy),
    .freeze(frz), .op(op), .pending(pend)
  );

  op_display_queue #(.DEPTH(DEPTH), .DWELL_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(f_rst_n), .instr(f_ins), .instr_valid(f_vld), .instr_ready(f_rdy),
    .freeze(1'b0), .op(f_op), .pending(f_pend)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] words [12] = '{
    32'hE3A01005, 32'hE0812002, 32'hE0423001, 32'hE0012003,
    32'hE1812003, 32'hE1510002, 32'hE1E01002, 32'hE5910000,
    32'hE5810000, 32'hEAFFFFFE, 32'hE12FFF1E, 32'hEE000010
  };
  int exp_codes [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};

  // Reference classifier: data-processing ops via a lookup table.
  function automatic int ref_class(input logic [31:0] w);
    int dp [16];
    foreach (dp[i]) dp[i] = 15;
    dp[13] = 0; dp[4] = 1; dp[2] = 2; dp[0] = 3;
    dp[12] = 4; dp[10] = 5; dp[15] = 6;
    if (w[27:4] == 24'h12FFF1) return 10;
    if (w[27:25] == 3'b101)    return 9;
    if (w[27:26] == 2'b01)     return w[20] ? 7 : 8;
    if (w[27:26] == 2'b00)     return dp[w[24:21]];
    return 15;
  endfunction

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 1) == 1) return words[$urandom_range(0, 11)];
    return $urandom();
  endfunction

  // Reference model: a queue of codes, the shown code, and the number of
  // unfrozen edges since the shown code was loaded.
  int mq[$];
  int m_op;
  int m_el;

  typedef struct { int op; int pend; int rdy; } exp_t;
  exp_t exp_q[$];

  task automatic m_reset();
    mq.delete();
    m_op = 15;
    m_el = DWELL;
  endtask

  task automatic m_edge(input logic v, input logic [31:0] w, input logic f);
    bit do_pop, do_push;
    do_pop  = (mq.size() > 0) && (m_el >= DWELL) && !f;
    do_push = v && (mq.size() < DEPTH);
    if (do_pop) begin
      m_op = mq.pop_front();
      m_el = 0;
    end else if (!f && m_el < DWELL) begin
      m_el++;
    end
    if (do_push) mq.push_back(ref_class(w));
  endtask

  function automatic exp_t m_now();
    exp_t e;
    e.op   = m_op;
    e.pend = mq.size();
    e.rdy  = (mq.size() < DEPTH) ? 1 : 0;
    return e;
  endfunction

  // Drives one cycle of inputs (from posedge+1), advances the model on the
  // edge and queues the expected post-edge outputs for the monitor.
  task automatic step(input logic v, input logic [31:0] w, input logic f);
    vld = v; ins = w; frz = f;
    @(posedge clk);
    if (rst_n) m_edge(v, w, f); else m_reset();
    #1;
    exp_q.push_back(m_now());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async_op", int'(op), 15);
    chk("reset_async_pending", int'(pend), 0);
    chk("reset_async_ready", int'(rdy), 1);
    m_reset();
    exp_q.delete();
    exp_q.push_back(m_now());
    step(1'b1, rand_word(), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Main monitor: one expected record per cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("op", int'(op), e.op);
      chk("pending", int'(pend), e.pend);
      chk("instr_ready", int'(rdy), e.rdy);
    end
  end

  // Classification scoreboard on the DWELL=1 instance: each accepted word
  // pushes its required code; every change of f_op pops one.
  int fq[$];
  int f_idx = 0;
  int f_seen = 0;
  int fcyc = 0;
  int f_lastcyc = 0;
  int f_last = 15;
  bit f_sent = 1'b0;

  initial begin : fast_drv
    bit acc;
    f_rst_n = 1'b0; f_vld = 1'b0; f_ins = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    f_rst_n = 1'b1;
    f_vld = 1'b1;
    f_ins = words[0];
    for (int c = 0; c < 200 && f_idx < 12; c++) begin
      @(negedge clk);
      acc = f_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        fq.push_back(exp_codes[f_idx]);
        f_idx++;
        if (f_idx < 12) f_ins = words[f_idx];
        else            f_vld = 1'b0;
      end
    end
    f_sent = 1'b1;
  end

  always @(negedge clk) begin : fast_mon
    if (f_rst_n) begin
      fcyc++;
      if (int'(f_op) != f_last) begin
        if (fq.size() == 0) chk("fast_unexpected_op", int'(f_op), f_last);
        else                chk("fast_op_seq", int'(f_op), fq.pop_front());
        if (f_seen > 0) chk("fast_min_gap", ((fcyc - f_lastcyc) >= 2) ? 1 : 0, 1);
        f_lastcyc = fcyc;
        f_seen++;
        f_last = int'(f_op);
      end
    end
  end

  initial begin : main
    int saved;
    rst_n = 1'b0; vld = 1'b0; frz = 1'b0; ins = 32'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op", int'(op), 15);
    chk("reset_pending", int'(pend), 0);
    chk("reset_ready", int'(rdy), 1);
    rst_n = 1'b1;

    // Dwell: ADD then SUB back-to-back.
    step(1'b1, 32'hE0812002, 1'b0);
    step(1'b1, 32'hE0423001, 1'b0);
    chk("dwell_first", int'(op), 1);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    chk("dwell_hold", int'(op), 1);
    step(1'b0, 32'h0, 1'b0);
    chk("dwell_next", int'(op), 2);
    idle(10);

    // Backpressure: valid held, 5 accepts fill the queue.
    for (int k = 0; k < 5; k++) step(1'b1, words[k + 3], 1'b0);
    chk("bp_ready", int'(rdy), 0);
    chk("bp_pending", int'(pend), 4);
    step(1'b1, words[11], 1'b0);
    step(1'b1, words[11], 1'b0);
    chk("bp_still_full", int'(pend), 4);
    chk("bp_still_blocked", int'(rdy), 0);
    for (int k = 0; k < 4; k++) step(1'b1, words[11], 1'b0);
    idle(60);

    // Freeze: two codes queued with the dwell expired.
    step(1'b1, words[0], 1'b1);
    step(1'b1, words[1], 1'b1);
    saved = m_op;
    chk("freeze_queued", int'(pend), 2);
    for (int k = 0; k < 20; k++) begin
      step(k < 2, words[k + 2], 1'b1);
      chk("freeze_hold", int'(op), saved);
    end
    step(1'b0, 32'h0, 1'b0);
    chk("freeze_release", int'(op), exp_codes[0]);
    idle(60);

    // Reset mid-stream with 3 codes queued.
    for (int k = 0; k < 4; k++) step(1'b1, words[k + 3], 1'b0);
    chk("pre_reset_pending", int'(pend), 3);
    do_reset();
    idle(30);
    chk("post_reset_op", int'(op), 15);
    chk("post_reset_pending", int'(pend), 0);

    // Randomized traffic with occasional freeze and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 85 : 30),
             rand_word(), $urandom_range(0, 99) < 10);
      end
    end

    // Empty hold.
    idle(60);
    saved = m_op;
    idle(1000);
    chk("empty_hold_op", int'(op), saved);
    chk("empty_hold_pending", int'(pend), 0);
    step(1'b1, words[9], 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("empty_new_push", int'(op), 9);

    for (int c = 0; c < 100 && !f_sent; c++) @(posedge clk);
    chk("fast_done", int'(f_sent), 1);
    chk("fast_all_shown", f_seen, 12);
    chk("fast_queue_drained", fq.size(), 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
